// File: rtl/compress_pkg.sv
// Shared definitions for the compressor ingress arbiter.
// Holds the default stream geometry, the FSM state encoding and the
// positions/values of the header fields that mark a packet as compressible
// (IPv4 / TCP, fixed total length and version/IHL byte, as seen on the
// byte-swapped 256-bit burst bus).
package compress_pkg;

    localparam int BURST_WIDTH   = 256;
    localparam int NUM_HDR_BEATS = 4;
    localparam int CNT_WIDTH     = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    // Low bit of each classified field inside header beat 0.
    localparam int ETHTYPE_LSB = 96;   // d[111:96]
    localparam int VER_IHL_LSB = 120;  // d[127:120]
    localparam int TOTLEN_LSB  = 128;  // d[143:128]
    localparam int PROTO_LSB   = 184;  // d[191:184]

    localparam logic [15:0] ETHTYPE_IPV4 = 16'h0008;
    localparam logic [7:0]  PROTO_TCP    = 8'h06;
    localparam logic [15:0] TOTLEN       = 16'hdc05;
    localparam logic [7:0]  VER_IHL      = 8'h28;

endpackage

// File: rtl/pkt_header_classifier.sv
// Combinational classifier for header beat 0 of a packet.
// Ports:
//   ethtype         in  16  EtherType field of beat 0
//   proto           in  8   IP protocol field of beat 0
//   total_len       in  16  IP total length field of beat 0
//   ver_ihl         in  8   IP version/IHL byte of beat 0
//   is_compressible out 1   all four fields match the compressible class
module pkt_header_classifier (
    input  logic [15:0] ethtype,
    input  logic [7:0]  proto,
    input  logic [15:0] total_len,
    input  logic [7:0]  ver_ihl,
    output logic        is_compressible
);
    import compress_pkg::*;

    assign is_compressible = (ethtype   == ETHTYPE_IPV4) &&
                             (proto     == PROTO_TCP)    &&
                             (total_len == TOTLEN)       &&
                             (ver_ihl   == VER_IHL);

endmodule

// File: rtl/compress_ingress_arbiter.sv
// Packet-granular round-robin arbiter feeding the compressor ingress from two
// upstream AXI-stream sources. A granted packet runs to its tlast before the
// other source is considered, so packets are never interleaved. Every forwarded
// beat is tagged with its source, a header-beat marker and the compressible
// flag derived from beat 0; completed packets are counted per class.
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   s0_*/s1_*               upstream streams (tvalid/tready/tdata/tlast)
//   m_tvalid/m_tready/m_tdata/m_tlast  stream to the compressor input FIFO
//   m_src                   granted source of the current beat
//   m_is_header             beat index < NUM_HDR_BEATS
//   m_flag_compression      packet belongs to the compressible class
//   state                   FSM state (IDLE=0, HDR=1, DATA=2)
//   pkt_cnt_comp/pkt_cnt_byp  completed compressible / bypass packet counts
//
// Handshake: a beat moves when valid and ready are both high on a rising edge.
// valid never depends on ready; once valid is raised the beat is held until it
// moves. The granted source sees m_tready directly as its tready, the other
// source always sees tready low, and the master side is a pure combinational
// pass-through of the granted source.
module compress_ingress_arbiter #(
    parameter int BURST_WIDTH   = compress_pkg::BURST_WIDTH,
    parameter int NUM_HDR_BEATS = compress_pkg::NUM_HDR_BEATS,
    parameter int CNT_WIDTH     = compress_pkg::CNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s0_tvalid,
    output logic                   s0_tready,
    input  logic [BURST_WIDTH-1:0] s0_tdata,
    input  logic                   s0_tlast,
    input  logic                   s1_tvalid,
    output logic                   s1_tready,
    input  logic [BURST_WIDTH-1:0] s1_tdata,
    input  logic                   s1_tlast,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [BURST_WIDTH-1:0] m_tdata,
    output logic                   m_tlast,
    output logic                   m_src,
    output logic                   m_is_header,
    output logic                   m_flag_compression,
    output logic [1:0]             state,
    output logic [CNT_WIDTH-1:0]   pkt_cnt_comp,
    output logic [CNT_WIDTH-1:0]   pkt_cnt_byp
);
    import compress_pkg::*;

    // Wide enough to hold NUM_HDR_BEATS (up to 8) once the header is done.
    localparam int              HC_W     = 4;
    localparam logic [HC_W-1:0] HDR_LAST = HC_W'(NUM_HDR_BEATS - 1);

    arb_state_t             state_q, state_d;
    logic                   grant_q, grant_d;
    logic                   last_grant_q, last_grant_d;
    logic [HC_W-1:0]        hdr_cnt_q, hdr_cnt_d;
    logic                   flag_q, flag_d;
    logic [CNT_WIDTH-1:0]   cnt_comp_q, cnt_comp_d;
    logic [CNT_WIDTH-1:0]   cnt_byp_q, cnt_byp_d;

    logic                   active;
    logic                   sel_valid;
    logic                   sel_last;
    logic [BURST_WIDTH-1:0] sel_data;
    logic                   beat0;
    logic                   beat0_flag;
    logic                   xfer;
    logic                   pkt_end;

    // Granted-source mux; the datapath carries no registers.
    assign sel_valid = grant_q ? s1_tvalid : s0_tvalid;
    assign sel_last  = grant_q ? s1_tlast  : s0_tlast;
    assign sel_data  = grant_q ? s1_tdata  : s0_tdata;

    pkt_header_classifier u_classifier (
        .ethtype         (sel_data[ETHTYPE_LSB +: 16]),
        .proto           (sel_data[PROTO_LSB +: 8]),
        .total_len       (sel_data[TOTLEN_LSB +: 16]),
        .ver_ihl         (sel_data[VER_IHL_LSB +: 8]),
        .is_compressible (beat0_flag)
    );

    assign active    = (state_q != ST_IDLE);
    assign m_tvalid  = active & sel_valid;
    assign m_tdata   = sel_data;
    assign m_tlast   = sel_last;
    assign m_src     = grant_q;
    assign s0_tready = active & ~grant_q & m_tready;
    assign s1_tready = active &  grant_q & m_tready;

    assign m_is_header = (state_q == ST_HDR);
    // Beat 0 is classified live; later beats reuse the value latched on beat 0.
    assign beat0              = (state_q == ST_HDR) && (hdr_cnt_q == '0);
    assign m_flag_compression = beat0 ? beat0_flag : flag_q;

    assign xfer    = m_tvalid & m_tready;
    assign pkt_end = xfer & sel_last;

    assign state        = state_q;
    assign pkt_cnt_comp = cnt_comp_q;
    assign pkt_cnt_byp  = cnt_byp_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        hdr_cnt_d    = hdr_cnt_q;
        flag_d       = flag_q;
        cnt_comp_d   = cnt_comp_q;
        cnt_byp_d    = cnt_byp_q;

        case (state_q)
            ST_IDLE: begin
                if (s0_tvalid || s1_tvalid) begin
                    // Prefer the source that did not win last time; fall back
                    // to the only one asking.
                    if (last_grant_q ? s0_tvalid : s1_tvalid) begin
                        grant_d = ~last_grant_q;
                    end else begin
                        grant_d = last_grant_q;
                    end
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    hdr_cnt_d = hdr_cnt_q + HC_W'(1);
                    if (beat0) begin
                        flag_d = beat0_flag;
                    end
                    if (sel_last) begin
                        state_d = ST_IDLE;
                    end else if (hdr_cnt_q == HDR_LAST) begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (pkt_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (pkt_end) begin
            last_grant_d = grant_q;
            hdr_cnt_d    = '0;
            if (m_flag_compression) begin
                cnt_comp_d = cnt_comp_q + CNT_WIDTH'(1);
            end else begin
                cnt_byp_d = cnt_byp_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            hdr_cnt_q    <= '0;
            flag_q       <= 1'b0;
            cnt_comp_q   <= '0;
            cnt_byp_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            hdr_cnt_q    <= hdr_cnt_d;
            flag_q       <= flag_d;
            cnt_comp_q   <= cnt_comp_d;
            cnt_byp_q    <= cnt_byp_d;
        end
    end

endmodule

// File: tb/tb_compress_ingress_arbiter.sv
module tb_compress_ingress_arbiter;

    localparam int W    = 256;
    localparam int NHDR = 4;
    localparam int EW   = W + 4;

    typedef struct {
        int len;
        int variant;   // 0 = compressible, 1..4 = one classified field wrong
        int pid;
    } pkt_t;

    typedef struct {
        logic [15:0] eth;
        logic [7:0]  proto;
        logic [15:0] totlen;
        logic [7:0]  verihl;
        logic        exp_flag;
    } cls_vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- main DUT ----------------
    logic         s_tvalid[2];
    logic [W-1:0] s_tdata[2];
    logic         s_tlast[2];
    logic         s0_tready, s1_tready;
    logic         m_tvalid, m_tready, m_tlast, m_src, m_is_header, m_flag_compression;
    logic [W-1:0] m_tdata;
    logic [1:0]   state;
    logic [31:0]  pkt_cnt_comp, pkt_cnt_byp;

    compress_ingress_arbiter dut (
        .clk(clk), .reset(reset),
        .s0_tvalid(s_tvalid[0]), .s0_tready(s0_tready), .s0_tdata(s_tdata[0]), .s0_tlast(s_tlast[0]),
        .s1_tvalid(s_tvalid[1]), .s1_tready(s1_tready), .s1_tdata(s_tdata[1]), .s1_tlast(s_tlast[1]),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .m_src(m_src), .m_is_header(m_is_header), .m_flag_compression(m_flag_compression),
        .state(state), .pkt_cnt_comp(pkt_cnt_comp), .pkt_cnt_byp(pkt_cnt_byp)
    );

    // ---------------- narrow-counter DUT for wrap ----------------
    logic         w_s0_tvalid, w_s0_tready, w_s0_tlast;
    logic [W-1:0] w_s0_tdata;
    logic         w_s1_tvalid, w_s1_tready, w_s1_tlast;
    logic [W-1:0] w_s1_tdata;
    logic         w_m_tvalid, w_m_tready, w_m_tlast, w_m_src, w_m_is_header, w_m_flag;
    logic [W-1:0] w_m_tdata;
    logic [1:0]   w_state;
    logic [2:0]   w_pkt_cnt_comp, w_pkt_cnt_byp;

    compress_ingress_arbiter #(.CNT_WIDTH(3)) dut_w (
        .clk(clk), .reset(reset),
        .s0_tvalid(w_s0_tvalid), .s0_tready(w_s0_tready), .s0_tdata(w_s0_tdata), .s0_tlast(w_s0_tlast),
        .s1_tvalid(w_s1_tvalid), .s1_tready(w_s1_tready), .s1_tdata(w_s1_tdata), .s1_tlast(w_s1_tlast),
        .m_tvalid(w_m_tvalid), .m_tready(w_m_tready), .m_tdata(w_m_tdata), .m_tlast(w_m_tlast),
        .m_src(w_m_src), .m_is_header(w_m_is_header), .m_flag_compression(w_m_flag),
        .state(w_state), .pkt_cnt_comp(w_pkt_cnt_comp), .pkt_cnt_byp(w_pkt_cnt_byp)
    );

    // ---------------- scoreboard state ----------------
    int          tests = 0;
    int          fails = 0;
    logic [EW-1:0] exp_q[$];
    pkt_t        pkts0[$];
    pkt_t        pkts1[$];
    logic [31:0] exp_comp = 0;
    logic [31:0] exp_byp  = 0;
    int          model_last = 1;
    int          next_pid = 0;
    bit          mon_en = 0;
    bit          gaps_en = 0;
    bit          phase_done = 0;
    int          tready_mode = 0;
    bit          prev_end = 0;

    task automatic check(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] make_beat(int s, int pid, int b, int variant);
        logic [W-1:0] d;
        logic [31:0]  word;
        word = {s[3:0], pid[11:0], b[15:0]};
        d = {8{word}};
        if (b == 0) begin
            d[111:96]  = 16'h0008;
            d[191:184] = 8'h06;
            d[143:128] = 16'hdc05;
            d[127:120] = 8'h28;
            case (variant)
                1: d[111:96]  = 16'h0800;
                2: d[191:184] = 8'h11;
                3: d[143:128] = 16'h05dc;
                4: d[127:120] = 8'h45;
                default: ;
            endcase
        end
        return d;
    endfunction

    function automatic void add_pkt(int s, int len, int variant);
        pkt_t p;
        p.len = len;
        p.variant = variant;
        p.pid = next_pid;
        next_pid++;
        if (s == 0) pkts0.push_back(p);
        else pkts1.push_back(p);
    endfunction

    // Reference model: sources are always ready with their next packet, so
    // whenever both have one pending the source that did not win last goes
    // next; otherwise the remaining source goes. Each beat is expected once.
    function automatic void build_expected();
        int   i0, i1, s;
        pkt_t pk;
        logic last_b, hdr_b, flag_b;
        i0 = 0;
        i1 = 0;
        while (i0 < pkts0.size() || i1 < pkts1.size()) begin
            if (i0 < pkts0.size() && i1 < pkts1.size()) s = (model_last == 1) ? 0 : 1;
            else s = (i0 < pkts0.size()) ? 0 : 1;
            if (s == 0) begin pk = pkts0[i0]; i0++; end
            else begin pk = pkts1[i1]; i1++; end
            flag_b = (pk.variant == 0);
            for (int b = 0; b < pk.len; b++) begin
                last_b = (b == pk.len - 1);
                hdr_b  = (b < NHDR);
                exp_q.push_back({s[0], last_b, hdr_b, flag_b, make_beat(s, pk.pid, b, pk.variant)});
            end
            if (flag_b) exp_comp = exp_comp + 1;
            else exp_byp = exp_byp + 1;
            model_last = s;
        end
    endfunction

    function automatic logic src_ready(int s);
        return (s == 0) ? s0_tready : s1_tready;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_ready(input int s, input string name, output bit ok);
        int k;
        k = 0;
        @(negedge clk);
        while (!src_ready(s) && k < 400) begin
            @(negedge clk);
            k++;
        end
        ok = src_ready(s);
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL %s: source %0d not accepted within 400 cycles", name, s);
        end
    endtask

    task automatic drive_src(input int s);
        pkt_t pk;
        int   n;
        bit   ok;
        n = (s == 0) ? pkts0.size() : pkts1.size();
        for (int i = 0; i < n; i++) begin
            pk = (s == 0) ? pkts0[i] : pkts1[i];
            for (int b = 0; b < pk.len; b++) begin
                if (b > 0 && gaps_en && $urandom_range(0, 3) == 0) begin
                    s_tvalid[s] = 1'b0;
                    repeat ($urandom_range(1, 2)) @(posedge clk);
                    #1;
                end
                s_tdata[s]  = make_beat(s, pk.pid, b, pk.variant);
                s_tlast[s]  = (b == pk.len - 1);
                s_tvalid[s] = 1'b1;
                wait_ready(s, "src_accept", ok);
                if (!ok) begin
                    s_tvalid[s] = 1'b0;
                    return;
                end
                @(posedge clk);
                #1;
            end
        end
        s_tvalid[s] = 1'b0;
        s_tlast[s]  = 1'b0;
    endtask

    task automatic drive_tready();
        while (!phase_done) begin
            case (tready_mode)
                0: m_tready = 1'b1;
                1: m_tready = 1'($urandom_range(0, 1));
                default: m_tready = ~m_tready;
            endcase
            @(posedge clk);
            #1;
        end
        m_tready = 1'b1;
    endtask

    task automatic run_phase(input int mode);
        int k;
        build_expected();
        tready_mode = mode;
        phase_done = 0;
        @(posedge clk);
        #1;
        fork
            drive_tready();
            begin
                fork
                    drive_src(0);
                    drive_src(1);
                join
                k = 0;
                while (exp_q.size() != 0 && k < 100) begin
                    @(posedge clk);
                    #1;
                    k++;
                end
                phase_done = 1;
            end
        join
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d beats never forwarded, required 0", exp_q.size());
            exp_q.delete();
        end
        check("pkt_cnt_comp", pkt_cnt_comp, exp_comp);
        check("pkt_cnt_byp", pkt_cnt_byp, exp_byp);
        pkts0.delete();
        pkts1.delete();
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (prev_end) begin
                check("bubble_state", state, 0);
                check("bubble_tvalid", m_tvalid, 0);
            end
            if (state == 2'd0) check("idle_tready", {s0_tready, s1_tready}, 0);
            check("nongrant_tready", m_src ? s0_tready : s1_tready, 0);
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL beat: unexpected beat %0h, none required", m_tdata);
                end else begin
                    check("beat", {m_src, m_tlast, m_is_header, m_flag_compression, m_tdata}, exp_q.pop_front());
                end
            end
            prev_end = m_tvalid && m_tready && m_tlast;
        end else begin
            prev_end = 0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    cls_vec_t     vecs[8];
    int           s, n0, n1, k;
    logic [W-1:0] d;
    bit           ok;

    initial begin
        vecs[0] = '{16'h0008, 8'h06, 16'hdc05, 8'h28, 1'b1};
        vecs[1] = '{16'h0800, 8'h06, 16'hdc05, 8'h28, 1'b0};
        vecs[2] = '{16'h0008, 8'h11, 16'hdc05, 8'h28, 1'b0};
        vecs[3] = '{16'h0008, 8'h06, 16'h05dc, 8'h28, 1'b0};
        vecs[4] = '{16'h0008, 8'h06, 16'hdc05, 8'h45, 1'b0};
        vecs[5] = '{16'h0000, 8'h00, 16'h0000, 8'h00, 1'b0};
        vecs[6] = '{16'h0008, 8'h06, 16'hdc05, 8'h28, 1'b1};
        vecs[7] = '{16'h0009, 8'h06, 16'hdc05, 8'h28, 1'b0};

        reset = 1'b1;
        m_tready = 1'b1;
        s_tvalid[0] = 1'b1; s_tvalid[1] = 1'b1;
        s_tdata[0] = '0;    s_tdata[1] = '0;
        s_tlast[0] = 1'b0;  s_tlast[1] = 1'b0;
        w_s0_tvalid = 1'b0; w_s0_tdata = '0; w_s0_tlast = 1'b0;
        w_s1_tvalid = 1'b0; w_s1_tdata = '0; w_s1_tlast = 1'b0;
        w_m_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", state, 0);
        check("rst_tready", {s0_tready, s1_tready}, 0);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_cnt_comp", pkt_cnt_comp, 0);
        check("rst_cnt_byp", pkt_cnt_byp, 0);
        s_tvalid[0] = 1'b0; s_tvalid[1] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mon_en = 1;

        // 6-beat compressible packet from s0
        add_pkt(0, 6, 0);
        run_phase(0);
        // 5-beat UDP packet from s1
        add_pkt(1, 5, 2);
        run_phase(0);
        // both sources continuously valid, 5-beat packets
        add_pkt(0, 5, 0); add_pkt(0, 5, 0);
        add_pkt(1, 5, 0); add_pkt(1, 5, 0);
        run_phase(0);
        // 8-beat packet with m_tready toggling
        add_pkt(0, 8, 0);
        run_phase(2);

        // randomized traffic
        for (int r = 0; r < 4; r++) begin
            n0 = $urandom_range(0, 5);
            n1 = $urandom_range(1, 5);
            repeat (n0) add_pkt(0, $urandom_range(1, 10), ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4));
            repeat (n1) add_pkt(1, $urandom_range(1, 10), ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4));
            gaps_en = 1;
            run_phase(1);
            gaps_en = 0;
        end

        // classifier table: single-beat packets
        mon_en = 0;
        m_tready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            s = i % 2;
            for (int j = 0; j < 8; j++) d[j*32 +: 32] = $urandom();
            d[111:96]  = vecs[i].eth;
            d[191:184] = vecs[i].proto;
            d[143:128] = vecs[i].totlen;
            d[127:120] = vecs[i].verihl;
            s_tdata[s] = d;
            s_tlast[s] = 1'b1;
            s_tvalid[s] = 1'b1;
            @(negedge clk);
            check("tbl_idle_state", state, 0);
            check("tbl_idle_tvalid", m_tvalid, 0);
            @(negedge clk);
            check("tbl_hdr_state", state, 1);
            check("tbl_tvalid", m_tvalid, 1);
            check("tbl_ready", src_ready(s), 1);
            check("tbl_src", m_src, s);
            check("tbl_is_header", m_is_header, 1);
            check("tbl_tlast", m_tlast, 1);
            check("tbl_data", m_tdata, d);
            check("tbl_flag", m_flag_compression, vecs[i].exp_flag);
            @(posedge clk);
            #1;
            s_tvalid[s] = 1'b0;
            s_tlast[s] = 1'b0;
            if (vecs[i].exp_flag) exp_comp = exp_comp + 1;
            else exp_byp = exp_byp + 1;
            model_last = s;
            @(negedge clk);
            check("tbl_end_state", state, 0);
            check("tbl_cnt_comp", pkt_cnt_comp, exp_comp);
            check("tbl_cnt_byp", pkt_cnt_byp, exp_byp);
            @(posedge clk);
            #1;
        end

        // reset in the middle of a packet (DATA, beat 5)
        for (int b = 0; b < 5; b++) begin
            s_tdata[0] = make_beat(0, next_pid, b, 0);
            s_tlast[0] = 1'b0;
            s_tvalid[0] = 1'b1;
            wait_ready(0, "rst_mid_accept", ok);
            @(posedge clk);
            #1;
        end
        s_tdata[0] = make_beat(0, next_pid, 5, 0);
        next_pid++;
        @(negedge clk);
        check("rst_mid_pre_state", state, 2);
        check("rst_mid_pre_hdr", m_is_header, 0);
        reset = 1'b1;
        s_tvalid[0] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_state", state, 0);
        check("rst_mid_tready", {s0_tready, s1_tready}, 0);
        check("rst_mid_tvalid", m_tvalid, 0);
        check("rst_mid_cnt_comp", pkt_cnt_comp, 0);
        check("rst_mid_cnt_byp", pkt_cnt_byp, 0);
        exp_comp = 0;
        exp_byp = 0;
        model_last = 1;
        mon_en = 1;

        // after reset s0 wins first
        add_pkt(1, 3, 1);
        add_pkt(0, 2, 0);
        run_phase(0);

        // counter wrap on the narrow-counter instance
        mon_en = 0;
        for (int i = 0; i < 9; i++) begin
            d = make_beat(0, 900 + i, 0, 0);
            w_s0_tdata = d;
            w_s0_tlast = 1'b1;
            w_s0_tvalid = 1'b1;
            k = 0;
            @(negedge clk);
            while (!w_s0_tready && k < 20) begin
                @(negedge clk);
                k++;
            end
            check("wrap_accept", w_s0_tready, 1);
            check("wrap_state", w_state, 1);
            check("wrap_beat", {w_m_tvalid, w_m_src, w_m_tlast, w_m_is_header, w_m_flag, w_m_tdata},
                  {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, d});
            check("wrap_s1_tready", w_s1_tready, 0);
            @(posedge clk);
            #1;
            w_s0_tvalid = 1'b0;
            w_s0_tlast = 1'b0;
            @(negedge clk);
            check("wrap_cnt_comp", w_pkt_cnt_comp, (i + 1) % 8);
            check("wrap_cnt_byp", w_pkt_cnt_byp, 0);
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
